// File: rtl/ram_sdp_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg : shared definitions for the ram_sdp block.
//
// Holds the initialisation FSM state type with its two state constants and
// the default word width / depth used as parameter defaults by ram_sdp and
// ram_sdp_if. Imported with "import ram_pkg::*;".
//
// Optional build macro used by ram_sdp: RAM_SDP_OUT_REG_EN.
// ----------------------------------------------------------------------------
package ram_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  typedef logic [0:0] state_t;

  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_READY = 1'b1;

endpackage

// File: rtl/ram_sdp_if.sv
// ----------------------------------------------------------------------------
// ram_sdp_if : write/read port bundle of the simple dual-port RAM.
//
// Signals:
//   wr_en, wr_addr, wr_data, wr_be : write request, address, data and byte
//                                    enables (bit i gates wr_data[8i+7:8i])
//   rd_en, rd_addr                 : read request and address
//   rd_data, rd_valid              : read result (held) and its 1-cycle strobe
//
// Modports:
//   master : the requester (drives requests, receives read results)
//   slave  : the RAM (receives requests, drives read results)
// ----------------------------------------------------------------------------
interface ram_sdp_if
  import ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = $clog2(DEF_DEPTH)
);

  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/ram_sdp_init_fsm.sv
// ----------------------------------------------------------------------------
// ram_sdp_init_fsm : post-reset memory clear sequencer.
//
// After rst_n deasserts the FSM sits in CLEAR for exactly DEPTH cycles,
// presenting addresses 0..DEPTH-1 with a write strobe so the RAM zeroes one
// word per cycle, then moves to READY and stays there until the next reset.
//
// Ports:
//   ck        : clock, rising edge
//   rst_n     : asynchronous active-low reset (restarts the clear at 0)
//   clr_addr  : address to be zeroed this cycle
//   clr_we    : clear write strobe, high for the whole CLEAR state
//   init_done : high once READY has been entered
// ----------------------------------------------------------------------------
module ram_sdp_init_fsm
  import ram_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              ck,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we,
  output logic              init_done
);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;

  // The counter steps through every word once; the last clear write and the
  // move to READY happen on the same edge, so the clear takes DEPTH cycles.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
        state <= ST_READY;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  assign clr_addr  = clr_cnt;
  assign clr_we    = (state == ST_CLEAR);
  assign init_done = (state == ST_READY);

endmodule

// File: rtl/ram_sdp.sv
// ----------------------------------------------------------------------------
// ram_sdp : simple dual-port RAM with byte enables and self-clear.
//
// One write port and one read port on a single clock. After reset the whole
// array is zeroed by ram_sdp_init_fsm; requests are ignored until init_done.
// Same-address read/write is write-first per byte. Out-of-range writes are
// dropped, out-of-range reads return 0 with rd_valid.
//
// Parameters: DATA_W (multiple of 8), DEPTH (>= 2), ADDR_W.
// Ports:
//   ck        : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : ram_sdp_if slave (write/read requests, rd_data, rd_valid)
//   init_done : high once the post-reset clear has finished
//
// Build macro RAM_SDP_OUT_REG_EN: adds an output register stage, read
// latency becomes 2 cycles (default build: 1 cycle).
// ----------------------------------------------------------------------------
module ram_sdp
  import ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic     ck,
  input  logic     rst_n,
  ram_sdp_if.slave bus,
  output logic     init_done
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we;
  logic              wr_ok;
  logic              rd_in_range;
  logic              rd_take;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_q;
  logic              rd_v_q;

  ram_sdp_init_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_fsm (
    .ck        (ck),
    .rst_n     (rst_n),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we),
    .init_done (init_done)
  );

  assign wr_ok       = init_done && bus.wr_en && (int'(bus.wr_addr) < DEPTH);
  assign rd_in_range = (int'(bus.rd_addr) < DEPTH);
  assign rd_take     = init_done && bus.rd_en;

  // Array has no reset; it is zeroed only by the clear sequence.
  always_ff @(posedge ck) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wr_be[i]) begin
          mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
        end
      end
    end
  end

  // Write-first bypass: bytes being written this cycle to the read address
  // come from wr_data, the rest from the array.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[bus.rd_addr];
      if (wr_ok && (bus.wr_addr == bus.rd_addr)) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.wr_be[i]) begin
            rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
          end
        end
      end
    end
  end

  // First read stage; rd_q holds its value when no read is taken.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      rd_v_q <= 1'b0;
    end else begin
      rd_v_q <= rd_take;
      if (rd_take) begin
        rd_q <= rd_word;
      end
    end
  end

`ifdef RAM_SDP_OUT_REG_EN
  logic [DATA_W-1:0] rd_q2;
  logic              rd_v_q2;

  // Optional output stage; only reloads when the first stage had new data.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      rd_q2   <= '0;
      rd_v_q2 <= 1'b0;
    end else begin
      rd_v_q2 <= rd_v_q;
      if (rd_v_q) begin
        rd_q2 <= rd_q;
      end
    end
  end

  assign bus.rd_data  = rd_q2;
  assign bus.rd_valid = rd_v_q2;
`else
  assign bus.rd_data  = rd_q;
  assign bus.rd_valid = rd_v_q;
`endif

endmodule

// File: tb/tb_ram_sdp.sv
// ----------------------------------------------------------------------------
// tb_ram_sdp : self-checking bench for ram_sdp.
//
// Two instances share one stimulus stream: dut_a (DATA_W=8, DEPTH=16) and
// dut_b (DATA_W=16, DEPTH=12, so addresses 12..15 are out of range). A
// behavioural model of both memories is stepped every clock and compared
// with the DUT outputs; directed sections add literal expectations.
// Honours RAM_SDP_OUT_REG_EN for the read latency.
// ----------------------------------------------------------------------------
module tb_ram_sdp;

`ifdef RAM_SDP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH_A = 16;
  localparam int DEPTH_B = 12;

  logic        ck      = 1'b0;
  logic        rst_n   = 1'b1;
  logic        wr_en   = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be   = '0;
  logic        rd_en   = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        init_a;
  logic        init_b;

  int compared   = 0;
  int mismatched = 0;

  ram_sdp_if #(.DATA_W(8),  .ADDR_W(4)) bus_a ();
  ram_sdp_if #(.DATA_W(16), .ADDR_W(4)) bus_b ();

  assign bus_a.wr_en   = wr_en;
  assign bus_a.wr_addr = wr_addr;
  assign bus_a.wr_data = wr_data[7:0];
  assign bus_a.wr_be   = wr_be[0];
  assign bus_a.rd_en   = rd_en;
  assign bus_a.rd_addr = rd_addr;

  assign bus_b.wr_en   = wr_en;
  assign bus_b.wr_addr = wr_addr;
  assign bus_b.wr_data = wr_data;
  assign bus_b.wr_be   = wr_be;
  assign bus_b.rd_en   = rd_en;
  assign bus_b.rd_addr = rd_addr;

  ram_sdp #(.DATA_W(8), .DEPTH(DEPTH_A)) dut_a (
    .ck        (ck),
    .rst_n     (rst_n),
    .bus       (bus_a),
    .init_done (init_a)
  );

  ram_sdp #(.DATA_W(16), .DEPTH(DEPTH_B)) dut_b (
    .ck        (ck),
    .rst_n     (rst_n),
    .bus       (bus_b),
    .init_done (init_b)
  );

  always #5 ck = ~ck;

  // Behavioural model: plain word arrays, a count of clock edges since
  // reset release, and a fixed-length delay line for read results.
  logic [15:0] mdl_mem  [2][16];
  int          mdl_cnt  [2];
  logic [16:0] mdl_pipe [2][LAT];
  logic [15:0] exp_data [2];
  logic        exp_valid[2];
  logic        exp_done [2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 0) ? DEPTH_A : DEPTH_B;
  endfunction

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_w, input logic [15:0] new_w,
                                              input logic [1:0] be, input int k);
    logic [15:0] r;
    r = old_w;
    for (int b = 0; b < ((k == 0) ? 1 : 2); b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  task automatic model_step();
    logic        rdy;
    logic        req;
    logic [15:0] val;
    int          dep;
    for (int k = 0; k < 2; k++) begin
      dep = depth_of(k);
      if (!rst_n) begin
        mdl_cnt[k] = 0;
        for (int i = 0; i < LAT; i++) mdl_pipe[k][i] = '0;
        exp_data[k]  = '0;
        exp_valid[k] = 1'b0;
        exp_done[k]  = 1'b0;
      end else begin
        rdy = (mdl_cnt[k] >= dep);
        req = rdy && rd_en;
        val = '0;
        if (req && (int'(rd_addr) < dep)) begin
          val = mdl_mem[k][rd_addr];
          if (wr_en && (wr_addr == rd_addr)) val = merge_bytes(val, wr_data, wr_be, k);
        end
        if (!rdy) begin
          mdl_mem[k][mdl_cnt[k]] = '0;
        end else if (wr_en && (int'(wr_addr) < dep)) begin
          mdl_mem[k][wr_addr] = merge_bytes(mdl_mem[k][wr_addr], wr_data, wr_be, k);
        end
        for (int i = LAT - 1; i > 0; i--) mdl_pipe[k][i] = mdl_pipe[k][i-1];
        mdl_pipe[k][0] = {req, val};
        exp_valid[k] = mdl_pipe[k][LAT-1][16];
        if (exp_valid[k]) exp_data[k] = mdl_pipe[k][LAT-1][15:0];
        if (mdl_cnt[k] < dep) mdl_cnt[k]++;
        exp_done[k] = (mdl_cnt[k] >= dep);
      end
    end
  endtask

  // Step the model on each rising edge, then compare just after it.
  always @(posedge ck) begin
    model_step();
    #1;
    checkOutput("a_rd_valid",  32'(bus_a.rd_valid), 32'(exp_valid[0]));
    checkOutput("a_rd_data",   32'(bus_a.rd_data),  32'(exp_data[0]));
    checkOutput("a_init_done", 32'(init_a),         32'(exp_done[0]));
    checkOutput("b_rd_valid",  32'(bus_b.rd_valid), 32'(exp_valid[1]));
    checkOutput("b_rd_data",   32'(bus_b.rd_data),  32'(exp_data[1]));
    checkOutput("b_init_done", 32'(init_b),         32'(exp_done[1]));
  end

  // Drive one cycle of requests at a falling edge; returns at the next one.
  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                               input logic [1:0] be, input logic re, input logic [3:0] ra);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = ra;
    @(negedge ck);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
  endtask

  // Asserts reset mid-cycle, checks outputs cleared at once, holds a cycle.
  task automatic apply_reset(input string tag);
    #2;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    checkOutput({tag, "_a_rd_valid"}, 32'(bus_a.rd_valid), 32'h0);
    checkOutput({tag, "_a_rd_data"},  32'(bus_a.rd_data),  32'h0);
    checkOutput({tag, "_a_init"},     32'(init_a),         32'h0);
    checkOutput({tag, "_b_rd_valid"}, 32'(bus_b.rd_valid), 32'h0);
    checkOutput({tag, "_b_rd_data"},  32'(bus_b.rd_data),  32'h0);
    checkOutput({tag, "_b_init"},     32'(init_b),         32'h0);
    @(negedge ck);
    @(negedge ck);
  endtask

  // Releases reset and counts rising edges until each init_done rises.
  task automatic release_and_wait();
    int na;
    int nb;
    na = 0;
    nb = 0;
    rst_n = 1'b1;
    for (int n = 1; n <= 40 && (na == 0 || nb == 0); n++) begin
      @(posedge ck);
      #1;
      if (init_a && na == 0) na = n;
      if (init_b && nb == 0) nb = n;
    end
    checkOutput("init_latency_a", 32'(na), 32'd16);
    checkOutput("init_latency_b", 32'(nb), 32'd12);
    @(negedge ck);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a));
    repeat (LAT) idle();
  endtask

  initial begin
    int j;
    #1 rst_n = 1'b0;
    @(negedge ck);
    @(negedge ck);
    checkOutput("rst_a_rd_valid", 32'(bus_a.rd_valid), 32'h0);
    checkOutput("rst_a_rd_data",  32'(bus_a.rd_data),  32'h0);
    checkOutput("rst_a_init",     32'(init_a),         32'h0);
    checkOutput("rst_b_init",     32'(init_b),         32'h0);
    release_and_wait();
    read_all();

    // Write 0xA5 at 3, read it back.
    applyStimulus(1'b1, 4'd3, 16'h00A5, 2'b11, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3);
    repeat (LAT - 1) idle();
    checkOutput("a5_a_valid", 32'(bus_a.rd_valid), 32'h1);
    checkOutput("a5_a_data",  32'(bus_a.rd_data),  32'hA5);
    checkOutput("a5_b_data",  32'(bus_b.rd_data),  32'h00A5);
    idle();
    checkOutput("a5_a_pulse_end", 32'(bus_a.rd_valid), 32'h0);
    checkOutput("a5_a_hold",      32'(bus_a.rd_data),  32'hA5);

    // Same-cycle partial write and read of address 5.
    applyStimulus(1'b1, 4'd5, 16'h1234, 2'b11, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'd5, 16'hABCD, 2'b01, 1'b1, 4'd5);
    repeat (LAT - 1) idle();
    checkOutput("wfirst_b_data", 32'(bus_b.rd_data), 32'h12CD);
    checkOutput("wfirst_a_data", 32'(bus_a.rd_data), 32'hCD);

    // Address 13: out of range for dut_b, in range for dut_a.
    applyStimulus(1'b1, 4'd13, 16'hFFFF, 2'b11, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd13);
    repeat (LAT - 1) idle();
    checkOutput("oor_b_valid", 32'(bus_b.rd_valid), 32'h1);
    checkOutput("oor_b_data",  32'(bus_b.rd_data),  32'h0);
    checkOutput("oor_a_data",  32'(bus_a.rd_data),  32'hFF);
    read_all();

    // Back-to-back reads of 0,1,2.
    applyStimulus(1'b1, 4'd0, 16'h0010, 2'b11, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'd1, 16'h0011, 2'b11, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'd2, 16'h0012, 2'b11, 1'b0, 4'd0);
    for (int step = 0; step < 3 + LAT; step++) begin
      if (step < 3) applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(step));
      else          idle();
      j = step - (LAT - 1);
      if (j >= 0 && j < 3) begin
        checkOutput("b2b_a_valid", 32'(bus_a.rd_valid), 32'h1);
        checkOutput("b2b_a_data",  32'(bus_a.rd_data),  32'h10 + 32'(j));
      end
    end

    // Randomized traffic.
    repeat (400) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                    2'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    read_all();

    // Reset while a read of a non-zero word is in flight.
    applyStimulus(1'b1, 4'd7, 16'h5A5A, 2'b11, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd7);
    apply_reset("rd_abort");

    // Reset again at clear cycle 7, then a full clear.
    rst_n = 1'b1;
    repeat (7) idle();
    apply_reset("clr_abort");
    release_and_wait();

    applyStimulus(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd7);
    repeat (LAT - 1) idle();
    checkOutput("cleared_a_valid", 32'(bus_a.rd_valid), 32'h1);
    checkOutput("cleared_a_data",  32'(bus_a.rd_data),  32'h0);
    checkOutput("cleared_b_data",  32'(bus_b.rd_data),  32'h0);
    read_all();
    repeat (2) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_sdp.md
RAM_SDP -- requirements
Module: ram_sdp

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 16, number of words; SHALL be at least 2 and need not be a power of 2.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 Port ck  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port wr_en  input  1  write request.
REQ-007 Port wr_addr  input  ADDR_W  write address.
REQ-008 Port wr_data  input  DATA_W  write data.
REQ-009 Port wr_be  input  DATA_W/8  byte enables; bit i gates wr_data[8i+7:8i].
REQ-010 Port rd_en  input  1  read request.
REQ-011 Port rd_addr  input  ADDR_W  read address.
REQ-012 Port rd_data  output  DATA_W  read data, held between reads.
REQ-013 Port rd_valid  output  1  one-cycle pulse marking new rd_data.
REQ-014 Port init_done  output  1  high once the memory clear has completed.

Function
REQ-015 The block SHALL use a two-state FSM with states CLEAR and READY, and SHALL enter CLEAR on reset.
REQ-016 In CLEAR, the block SHALL write zero to address clr_cnt each cycle, with clr_cnt stepping 0..DEPTH-1, then go to READY; clearing takes exactly DEPTH cycles after rst_n deasserts.
REQ-017 init_done SHALL rise on the edge that enters READY and SHALL stay high until the next reset.
REQ-018 In CLEAR, wr_en and rd_en SHALL be ignored, rd_valid SHALL stay 0, and rd_data SHALL stay 0.
REQ-019 In READY, wr_en=1 with an in-range address SHALL update only the bytes whose wr_be bit is 1; wr_be=0 SHALL leave the word unchanged.
REQ-020 In READY, rd_en=1 SHALL load rd_data and pulse rd_valid on the next edge (latency 1).
REQ-021 rd_data SHALL hold its last value when no read is accepted.
REQ-022 Read and write to the same address in the same cycle SHALL be write-first: enabled bytes return wr_data, other bytes return the old contents.
REQ-023 A write with address >= DEPTH SHALL be dropped.
REQ-024 A read with address >= DEPTH SHALL return 0 with rd_valid asserted.
REQ-025 Back-to-back reads SHALL each be accepted, giving one rd_valid pulse per read with no bubbles.

Reset
REQ-026 Asserting rst_n low SHALL immediately set rd_data=0, rd_valid=0, init_done=0, clr_cnt=0 and state=CLEAR.
REQ-027 Reset mid-clear or mid-read SHALL abort the operation; in-flight read results SHALL be discarded and the clear SHALL restart at address 0.
REQ-028 Memory array contents SHALL not be reset directly; they are zeroed only by the CLEAR sequence.

Configuration
REQ-029 Macro RAM_SDP_OUT_REG_EN defined: the block SHALL add an output register stage, making read latency 2; rd_valid SHALL be delayed to match, and write-first merging SHALL be evaluated at request time.
REQ-030 Macro RAM_SDP_OUT_REG_EN undefined: read latency SHALL be 1 as in REQ-020.
REQ-031 The output register stage SHALL also reset to 0.

Structure
REQ-032 Package ram_pkg SHALL hold the FSM state typedef (ST_CLEAR, ST_READY) and the default DATA_W/DEPTH constants.
REQ-033 The CLEAR/READY FSM and clr_cnt SHALL be a sub-module, ram_sdp_init_fsm, which outputs the clear address, clear write strobe and init_done.

Verification
REQ-034 Scenario: release rst_n with DEPTH=16 -> init_done rises exactly 16 cycles later, and reads of all addresses return 0x00.
REQ-035 Scenario: write 0xA5 at address 3, then read address 3 -> rd_data=0xA5 with a one-cycle rd_valid one cycle after rd_en (two cycles with RAM_SDP_OUT_REG_EN).
REQ-036 Scenario: DATA_W=16, word holds 0x1234, same-cycle write 0xABCD with wr_be=2'b01 and read of the same address -> rd_data=0x12CD.
REQ-037 Scenario: DEPTH=12, write 0xFF at address 13, then read address 13 -> rd_data=0 with rd_valid=1, and addresses 0..11 are unchanged.
REQ-038 Scenario: assert rst_n low at clear cycle 7 and during a pending read -> rd_valid=0 and rd_data=0 at once, and init_done rises 16 cycles after release.
REQ-039 Scenario: reads of addresses 0,1,2 on consecutive cycles after writing 0x10,0x11,0x12 -> three consecutive rd_valid pulses with data 0x10,0x11,0x12.
